// File: rtl/irq_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched_if
// Brief    : Memory-mapped configuration bus between software bridge and
//            the interrupt scheduler.
// Revision : 1.0
// ============================================================================
interface irq_sched_if;
    logic        cfg_we;
    logic        cfg_re;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_we,
        output cfg_re,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_re,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface
`default_nettype wire

// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched
// Brief    : Six-source interrupt scheduler driving CP0 HWInt with a fixed
//            priority one-hot request and a claim/complete handshake.
// Revision : 1.0
// ============================================================================
module irq_sched #(
    parameter int NSRC = 6,
    parameter int CNTW = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [NSRC-1:0] irq_src,
    irq_sched_if.slave           cfg,
    output logic [NSRC-1:0]      hwint
);

    localparam logic [2:0] c_ADDR_EN       = 3'd0;
    localparam logic [2:0] c_ADDR_MODE     = 3'd1;
    localparam logic [2:0] c_ADDR_PEND     = 3'd2;
    localparam logic [2:0] c_ADDR_CLAIM    = 3'd3;
    localparam logic [2:0] c_ADDR_COMPLETE = 3'd4;
    localparam logic [2:0] c_ADDR_STATUS   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NSRC-1:0] r_s1;
    logic [NSRC-1:0] r_s2;
    logic [NSRC-1:0] r_s3;
    logic [NSRC-1:0] r_en;
    logic [NSRC-1:0] r_mode;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_hwint;
    logic [2:0]      r_insvc;
    logic [CNTW-1:0] r_cnt;
    logic            r_err;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_hwint_nxt;
    logic [2:0]      w_win;
    logic            w_any;
    logic            w_wr_en;
    logic            w_wr_mode;
    logic            w_wr_pend;
    logic            w_wr_cmpl;
    logic            w_claim;
    logic            w_cmpl_ok;
    logic            w_cmpl_bad;
    logic [31:0]     w_status;

    assign w_edge = r_s2 & ~r_s3;
    assign w_elig = r_pend & r_en;
    assign w_any  = |w_elig;

    // Ascending scan so the highest eligible index is the last one kept.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_elig[i]) begin
                w_win = i[2:0];
            end
        end
    end

    assign w_wr_en    = cfg.cfg_we && (cfg.cfg_addr == c_ADDR_EN);
    assign w_wr_mode  = cfg.cfg_we && (cfg.cfg_addr == c_ADDR_MODE);
    assign w_wr_pend  = cfg.cfg_we && (cfg.cfg_addr == c_ADDR_PEND);
    assign w_wr_cmpl  = cfg.cfg_we && (cfg.cfg_addr == c_ADDR_COMPLETE);
    assign w_claim    = cfg.cfg_re && (cfg.cfg_addr == c_ADDR_CLAIM)
                        && (r_state == ST_ASSERT) && w_any;
    assign w_cmpl_ok  = w_wr_cmpl && (r_state == ST_SERVICE)
                        && (cfg.cfg_wdata[2:0] == r_insvc);
    assign w_cmpl_bad = w_wr_cmpl && !w_cmpl_ok;

    // Edge sources: a new edge beats a simultaneous claim or W1C clear.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NSRC; i++) begin
            if (r_mode[i]) begin
                if (w_edge[i]) begin
                    w_pend_nxt[i] = 1'b1;
                end else if ((w_claim && (w_win == i[2:0]))
                             || (w_wr_pend && cfg.cfg_wdata[i])) begin
                    w_pend_nxt[i] = 1'b0;
                end
            end else begin
                w_pend_nxt[i] = r_s2[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_claim) begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (w_cmpl_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Request is registered off the next state so it lines up with ASSERT.
        w_hwint_nxt = '0;
        if (w_state_nxt == ST_ASSERT) begin
            w_hwint_nxt[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_en    <= '0;
            r_mode  <= '0;
            r_pend  <= '0;
            r_hwint <= '0;
            r_insvc <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s1    <= irq_src;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pend  <= w_pend_nxt;
            r_hwint <= w_hwint_nxt;
            if (w_wr_en) begin
                r_en <= cfg.cfg_wdata[NSRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= cfg.cfg_wdata[NSRC-1:0];
            end
            if (w_claim) begin
                r_insvc <= w_win;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end
            if (w_cmpl_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_status           = '0;
        w_status[31]       = r_err;
        w_status[CNTW+7:8] = r_cnt;
        w_status[6:4]      = r_insvc;
        w_status[1:0]      = r_state;

        cfg.cfg_rdata = '0;
        case (cfg.cfg_addr)
            c_ADDR_EN:     cfg.cfg_rdata[NSRC-1:0] = r_en;
            c_ADDR_MODE:   cfg.cfg_rdata[NSRC-1:0] = r_mode;
            c_ADDR_PEND:   cfg.cfg_rdata[NSRC-1:0] = r_pend;
            c_ADDR_CLAIM: begin
                if ((r_state == ST_ASSERT) && w_any) begin
                    cfg.cfg_rdata = {1'b1, 28'b0, w_win};
                end
            end
            c_ADDR_STATUS: cfg.cfg_rdata = w_status;
            default:       cfg.cfg_rdata = '0;
        endcase
    end

    assign hwint = r_hwint;

endmodule
`default_nettype wire
